// File: rtl/alu_ctrl_exec_if.sv
// rtl/alu_ctrl_exec_if.sv - request/response bundle for the ALU control and execute unit
interface alu_ctrl_exec_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic            funct7b0;
  logic            op_5;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [3:0]      alu_con;
  logic            zero;
  logic            err;

  modport master (
    output in_valid, alu_op, funct3, funct7b5, funct7b0, op_5, a, b, out_ready,
    input  in_ready, out_valid, result, alu_con, zero, err
  );

  modport slave (
    input  in_valid, alu_op, funct3, funct7b5, funct7b0, op_5, a, b, out_ready,
    output in_ready, out_valid, result, alu_con, zero, err
  );
endinterface

// File: rtl/alu_ctrl_exec.sv
// rtl/alu_ctrl_exec.sv - RV32I ALU decode/execute with iterative shifter and registered handshake result
// Optional iterative shift-add multiplier enabled by defining ALU_MUL_EN.
module alu_ctrl_exec #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_ctrl_exec_if.slave bus
);
  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] STEP_W = CW'(SHIFT_STEP);

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_XOR  = 4'b0011;
  localparam logic [3:0] C_SLL  = 4'b0100;
  localparam logic [3:0] C_SRL  = 4'b0101;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_SLTU = 4'b1000;
  localparam logic [3:0] C_SRA  = 4'b1101;
  localparam logic [3:0] C_ILL  = 4'b1111;
`ifdef ALU_MUL_EN
  localparam logic [3:0] C_MUL  = 4'b1001;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [3:0]      con_q, con_d;
  logic [CW-1:0]   cnt_q, cnt_d;
`ifdef ALU_MUL_EN
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
`endif

  logic [3:0]      dec_con;
  logic [XLEN-1:0] alu_out;
  logic [SW-1:0]   shamt;
  logic            dec_shift;
  logic [CW-1:0]   step;
  logic [XLEN-1:0] shifted;

  assign shamt     = bus.b[SW-1:0];
  assign dec_shift = (dec_con == C_SLL) || (dec_con == C_SRL) || (dec_con == C_SRA);
  assign step      = (cnt_q < STEP_W) ? cnt_q : STEP_W;

  always_comb begin
    dec_con = C_ILL;
    case (bus.alu_op)
      2'b00: dec_con = C_ADD;
      2'b01: dec_con = C_SUB;
      2'b11: dec_con = C_ILL;
      default: begin
        if (bus.op_5 && bus.funct7b0) begin
`ifdef ALU_MUL_EN
          dec_con = (bus.funct3 == 3'b000) ? C_MUL : C_ILL;
`else
          dec_con = C_ILL;
`endif
        end else begin
          case (bus.funct3)
            3'b000:  dec_con = (bus.op_5 && bus.funct7b5) ? C_SUB : C_ADD;
            3'b001:  dec_con = C_SLL;
            3'b010:  dec_con = C_SLT;
            3'b011:  dec_con = C_SLTU;
            3'b100:  dec_con = C_XOR;
            3'b101:  dec_con = bus.funct7b5 ? C_SRA : C_SRL;
            3'b110:  dec_con = C_OR;
            default: dec_con = C_AND;
          endcase
        end
      end
    endcase
  end

  // Single-cycle results; ILLEGAL and the iterative ops fall through to zero.
  always_comb begin
    alu_out = '0;
    case (dec_con)
      C_AND:   alu_out = bus.a & bus.b;
      C_OR:    alu_out = bus.a | bus.b;
      C_ADD:   alu_out = bus.a + bus.b;
      C_XOR:   alu_out = bus.a ^ bus.b;
      C_SUB:   alu_out = bus.a - bus.b;
      C_SLT:   alu_out = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      C_SLTU:  alu_out = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
      default: alu_out = '0;
    endcase
  end

  always_comb begin
    shifted = '0;
    case (con_q)
      C_SLL:   shifted = res_q << step;
      C_SRL:   shifted = res_q >> step;
      default: shifted = XLEN'($signed(res_q) >>> step);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    con_d    = con_q;
    cnt_d    = cnt_q;
`ifdef ALU_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          con_d = dec_con;
          if (dec_shift) begin
            res_d   = bus.a;
            cnt_d   = {1'b0, shamt};
            state_d = (shamt == '0) ? DONE : BUSY;
`ifdef ALU_MUL_EN
          end else if (dec_con == C_MUL) begin
            res_d    = '0;
            mcand_d  = bus.a;
            mplier_d = bus.b;
            cnt_d    = CW'(XLEN);
            state_d  = BUSY;
`endif
          end else begin
            res_d   = alu_out;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
`ifdef ALU_MUL_EN
        if (con_q == C_MUL) begin
          if (mplier_q[0]) res_d = res_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = DONE;
        end else
`endif
        begin
          res_d = shifted;
          cnt_d = cnt_q - step;
          if (cnt_q == step) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      res_q    <= '0;
      con_q    <= C_AND;
      cnt_q    <= '0;
`ifdef ALU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      con_q    <= con_d;
      cnt_q    <= cnt_d;
`ifdef ALU_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = res_q;
  assign bus.alu_con   = con_q;
  assign bus.zero      = (state_q == DONE) && (res_q == '0);
  assign bus.err       = (state_q == DONE) && (con_q == C_ILL);
endmodule
